rbk_grp_sched: RTL and testbench

- Ping-pong group scheduler for the Rubik CSB register file.
- Tracks per-group state (IDLE/PENDING/RUNNING) for the two register groups, in strict alternating order.
- Launches the pending group onto the Rubik datapath and retires it on datapath done.
- Owns the consumer pointer and the status_0/status_1 fields that the single-register block reads back.

---
 rtl/rbk_grp_pkg.sv | 8 +
 rtl/rbk_grp_slot.sv | 29 ++
 rtl/rbk_grp_sched.sv | 68 ++++++
 tb/tb_rbk_grp_sched.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rbk_grp_pkg.sv
// rbk_grp_pkg: shared encodings for the Rubik ping-pong group scheduler.
package rbk_grp_pkg;
  localparam int NUM_GRP = 2;
  localparam int STATUS_W = 2;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {GRP_IDLE = 2'd0, GRP_RUNNING = 2'd1, GRP_PENDING = 2'd2} grp_st_t;
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} fsm_st_t;
endpackage

// File: rtl/rbk_grp_slot.sv
// rbk_grp_slot: per-group IDLE/PENDING/RUNNING state with op_en error detection.
module rbk_grp_slot
  import rbk_grp_pkg::*;
(
  input  logic    nvdla_core_clk,
  input  logic    nvdla_core_rst,
  input  logic    wr,
  input  logic    launch,
  input  logic    done,
  output grp_st_t st,
  output logic    op_en,
  output logic    err
);
  grp_st_t st_nx;
  // a re-arm landing on the retire cycle goes straight back to PENDING
  always_comb st_nx = done ? (wr ? GRP_PENDING : GRP_IDLE) :
                      launch ? GRP_RUNNING :
                      (wr && st == GRP_IDLE) ? GRP_PENDING : st;
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      st  <= GRP_IDLE;
      err <= 1'b0;
    end else begin
      st  <= st_nx;
      err <= wr && st != GRP_IDLE && !done;
    end
  end
  assign op_en = st != GRP_IDLE;
endmodule

// File: rtl/rbk_grp_sched.sv
// rbk_grp_sched: strict-alternation launch/retire controller for the two Rubik register groups.
module rbk_grp_sched #(
  parameter int NUM_GRP  = rbk_grp_pkg::NUM_GRP,
  parameter int STATUS_W = rbk_grp_pkg::STATUS_W,
  parameter int CNT_W    = rbk_grp_pkg::CNT_W
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                op_en_wr,
  input  logic                op_en_grp,
  input  logic                dp_ready,
  input  logic                op_done,
  output logic                consumer,
  output logic [STATUS_W-1:0] status_0,
  output logic [STATUS_W-1:0] status_1,
  output logic                grp0_op_en,
  output logic                grp1_op_en,
  output logic                op_launch,
  output logic                op_launch_grp,
  output logic [NUM_GRP-1:0]  done_intr,
  output logic                op_en_err,
  output logic [CNT_W-1:0]    layer_cnt
);
  import rbk_grp_pkg::*;
  fsm_st_t state, state_nx;
  grp_st_t st [NUM_GRP];
  logic [NUM_GRP-1:0] op_en, err;
  logic launch_go, done_go;
  always_comb begin
    launch_go = state == S_IDLE && st[consumer] == GRP_PENDING && dp_ready;
    done_go   = state == S_BUSY && op_done;
    state_nx  = launch_go ? S_BUSY : done_go ? S_IDLE : state;
  end
  for (genvar g = 0; g < NUM_GRP; g++) begin : g_slot
    rbk_grp_slot u_slot (
      .nvdla_core_clk (nvdla_core_clk),
      .nvdla_core_rst (nvdla_core_rst),
      .wr             (op_en_wr && op_en_grp == 1'(g)),
      .launch         (launch_go && consumer == 1'(g)),
      .done           (done_go && consumer == 1'(g)),
      .st             (st[g]),
      .op_en          (op_en[g]),
      .err            (err[g])
    );
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state         <= S_IDLE;
      consumer      <= 1'b0;
      op_launch     <= 1'b0;
      op_launch_grp <= 1'b0;
      done_intr     <= '0;
      layer_cnt     <= '0;
    end else begin
      state     <= state_nx;
      op_launch <= launch_go;
      if (launch_go) op_launch_grp <= consumer;
      done_intr <= done_go ? NUM_GRP'(1) << consumer : '0;
      layer_cnt <= layer_cnt + CNT_W'(done_go);
      consumer  <= consumer ^ done_go;
    end
  end
  assign status_0   = STATUS_W'(st[0]);
  assign status_1   = STATUS_W'(st[1]);
  assign grp0_op_en = op_en[0];
  assign grp1_op_en = op_en[1];
  assign op_en_err  = |err;
endmodule

// File: tb/tb_rbk_grp_sched.sv
// tb_rbk_grp_sched: scoreboard bench driving directed and random traffic against a behavioural model.
module tb_rbk_grp_sched;
  logic clk = 0, rst = 1, op_en_wr = 0, op_en_grp = 0, dp_ready = 0, op_done = 0;
  logic consumer, grp0_op_en, grp1_op_en, op_launch, op_launch_grp, op_en_err;
  logic [1:0] status_0, status_1, done_intr;
  logic [15:0] layer_cnt;

  rbk_grp_sched dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .op_en_wr       (op_en_wr),
    .op_en_grp      (op_en_grp),
    .dp_ready       (dp_ready),
    .op_done        (op_done),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .grp0_op_en     (grp0_op_en),
    .grp1_op_en     (grp1_op_en),
    .op_launch      (op_launch),
    .op_launch_grp  (op_launch_grp),
    .done_intr      (done_intr),
    .op_en_err      (op_en_err),
    .layer_cnt      (layer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; bit launch; bit lgrp; bit [1:0] dintr; bit err;
    int st0; int st1; bit cons; int cnt;
  } snap_t;
  snap_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0;

  // model: group state 0 idle / 1 running / 2 pending, one busy flag for the datapath
  int gs[2];
  int m_cons = 0, m_cnt = 0;
  bit m_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input bit r, input bit w, input bit g, input bit rdy, input bit d);
    snap_t s;
    bit launch, retire;
    int ng[2];
    @(negedge clk);
    rst = r; op_en_wr = w; op_en_grp = g; dp_ready = rdy; op_done = d;
    s.cyc = cyc + 1;
    if (r) begin
      gs[0] = 0; gs[1] = 0; m_cons = 0; m_cnt = 0; m_busy = 0;
      s.launch = 0; s.lgrp = 0; s.dintr = 0; s.err = 0;
    end else begin
      launch = !m_busy && gs[m_cons] == 2 && rdy;
      retire = m_busy && d;
      ng = gs;
      s.err = w && gs[g] != 0 && !(retire && int'(g) == m_cons);
      if (w && gs[g] == 0) ng[g] = 2;
      if (retire) ng[m_cons] = (w && int'(g) == m_cons) ? 2 : 0;
      if (launch) ng[m_cons] = 1;
      s.launch = launch;
      s.lgrp = bit'(m_cons);
      s.dintr = retire ? (m_cons == 1 ? 2'b10 : 2'b01) : 2'b00;
      m_cnt = retire ? (m_cnt + 1) % 65536 : m_cnt;
      m_busy = launch ? 1 : retire ? 0 : m_busy;
      m_cons = retire ? 1 - m_cons : m_cons;
      gs = ng;
    end
    s.st0 = gs[0]; s.st1 = gs[1]; s.cons = bit'(m_cons); s.cnt = m_cnt;
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n, input bit rdy = 1);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
  endtask

  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (e.cyc != cyc || op_launch != e.launch || (e.launch && op_launch_grp != e.lgrp) ||
            done_intr != e.dintr || op_en_err != e.err || int'(status_0) != e.st0 ||
            int'(status_1) != e.st1 || consumer != e.cons || int'(layer_cnt) != e.cnt ||
            grp0_op_en != (e.st0 != 0) || grp1_op_en != (e.st1 != 0)) begin
          fails++;
          $display("FAIL snap cyc=%0d(exp %0d): got launch=%0d grp=%0d intr=%b err=%0d st=%0d/%0d en=%0d%0d cons=%0d cnt=%0d; want launch=%0d grp=%0d intr=%b err=%0d st=%0d/%0d cons=%0d cnt=%0d",
                   cyc, e.cyc, op_launch, op_launch_grp, done_intr, op_en_err, status_0, status_1,
                   grp0_op_en, grp1_op_en, consumer, layer_cnt, e.launch, e.lgrp, e.dintr, e.err,
                   e.st0, e.st1, e.cons, e.cnt);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0); idle(6); step(0, 0, 0, 1, 1); idle(2);
    step(0, 1, 1, 1, 0); step(0, 1, 0, 1, 0); idle(4); step(0, 0, 0, 1, 1); idle(4);
    step(0, 0, 0, 1, 1); idle(2);
    step(0, 1, 0, 1, 0); idle(20);
    step(0, 1, 1, 1, 0); idle(3); step(0, 0, 0, 1, 1); idle(3); step(0, 0, 0, 1, 1); idle(2);
    step(0, 1, 1, 1, 0); idle(3); step(0, 1, 1, 1, 0); idle(2); step(0, 1, 1, 1, 1); idle(3);
    step(0, 0, 0, 1, 1); idle(2);
    step(0, 1, 1, 0, 0); idle(8, 0); idle(3); step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1); idle(2);
    step(0, 1, 0, 1, 0); idle(3); step(1, 0, 0, 1, 0); step(0, 0, 0, 1, 1); idle(3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    idle(2);
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d snapshots left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
